// File: rtl/perceptron_pkg.sv
// Shared types and byte codes for the perceptron command sequencer.
// Pure declarations: no logic, no latency, no flow control.
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        LOAD_B = 3'd2,
        LOAD_X = 3'd3,
        CLR    = 3'd4,
        RUN    = 3'd5,
        WAIT   = 3'd6,
        RESP   = 3'd7
    } state_t;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_B = 8'h42;
    localparam logic [7:0] CMD_X = 8'h58;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    localparam logic [1:0] MEM_SEL_W = 2'd0;
    localparam logic [1:0] MEM_SEL_X = 2'd1;
    localparam logic [1:0] MEM_SEL_B = 2'd2;

endpackage

// File: rtl/perceptron_if.sv
// UART byte, datapath register-write and MAC control bundle between controller and perceptron_top.
// Wires only: no latency; tx uses valid/ready, rx is a one-cycle strobe with no backpressure.
interface perceptron_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              mem_we;
    logic [1:0]        mem_sel;
    logic [7:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mac_clr;
    logic              mac_en;
    logic [7:0]        mac_addr;
    logic [ACC_W-1:0]  acc;

    modport master (
        input  rx_data, rx_valid, tx_ready, acc,
        output tx_data, tx_valid, mem_we, mem_sel, mem_addr, mem_wdata,
               mac_clr, mac_en, mac_addr
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, acc,
        input  tx_data, tx_valid, mem_we, mem_sel, mem_addr, mem_wdata,
               mac_clr, mac_en, mac_addr
    );

endinterface

// File: rtl/perceptron_tx_seq.sv
// Reply sequencer: sends first_byte then, with PERCEPTRON_ACC_DUMP_EN, the acc latched at start, MSB first.
// Latency: tx_valid rises the cycle after start; one byte per accepted handshake.
// Backpressure: tx_valid/tx_data held until tx_ready; done pulses with the last acceptance.
module perceptron_tx_seq
`ifdef PERCEPTRON_ACC_DUMP_EN
#(
    parameter int ACC_W = 20
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       first_byte,
    input  logic [7:0]       n_bytes,
`ifdef PERCEPTRON_ACC_DUMP_EN
    input  logic [ACC_W-1:0] acc,
`endif
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    output logic             done
);

    logic [7:0] rem_q;
    logic       accept;

    assign accept = tx_valid && tx_ready;
    assign done   = accept && (rem_q == 8'd1);

`ifdef PERCEPTRON_ACC_DUMP_EN
    localparam int EXT_W = ((ACC_W + 7) / 8) * 8;

    logic [EXT_W-1:0] acc_sh_q;

    // Sign-extended to a whole number of bytes so the top byte is always the next one out.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_sh_q <= '0;
        end else if (start) begin
            acc_sh_q <= EXT_W'($signed(acc));
        end else if (accept) begin
            acc_sh_q <= acc_sh_q << 8;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
            rem_q    <= 8'd0;
        end else if (start) begin
            tx_valid <= (n_bytes != 8'd0);
            tx_data  <= first_byte;
            rem_q    <= n_bytes;
        end else if (accept) begin
            rem_q    <= rem_q - 8'd1;
            tx_valid <= (rem_q != 8'd1);
`ifdef PERCEPTRON_ACC_DUMP_EN
            tx_data  <= acc_sh_q[EXT_W-1 -: 8];
`endif
        end
    end

endmodule

// File: rtl/perceptron_ctrl.sv
// Perceptron command sequencer: parses W/B/X host bytes, loads datapath registers, runs one MAC pass, replies.
// Latency: X last byte -> tx_valid = 3 + N_INPUTS + MAC_LAT cycles; W/B ACK 2 cycles; NAK 1 cycle.
// Backpressure: rx cannot be stalled (bytes outside capture are dropped, rx_overrun set); reply held until tx_ready.
// Build option PERCEPTRON_ACC_DUMP_EN appends the sign-extended accumulator to the class byte.
module perceptron_ctrl
    import perceptron_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 20,
    parameter int MAC_LAT  = 2
) (
    input  logic         clk,
    input  logic         rst,
    perceptron_if.master bus,
    output logic         rx_overrun,
    output logic         busy
);

    localparam logic [7:0] N_CNT  = 8'(N_INPUTS);
    localparam logic [7:0] N_LAST = 8'(N_INPUTS - 1);
    localparam logic [7:0] W_LAST = 8'((MAC_LAT > 0) ? (MAC_LAT - 1) : 0);
`ifdef PERCEPTRON_ACC_DUMP_EN
    localparam logic [7:0] RESULT_BYTES = 8'(1 + (ACC_W + 7) / 8);
`else
    localparam logic [7:0] RESULT_BYTES = 8'd1;
`endif

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        load_len;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic              ovr_set;
    logic              tx_start;
    logic [7:0]        tx_first;
    logic [7:0]        tx_count;
    logic              tx_done;
    logic [7:0]        tx_data_w;
    logic              tx_valid_w;
    logic [7:0]        class_byte;
    logic              mac_clr_c;
    logic              mac_en_c;
    logic [7:0]        mac_addr_c;
    logic              mem_we_q;
    logic [1:0]        mem_sel_q;
    logic [7:0]        mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    assign class_byte = {7'd0, ~bus.acc[ACC_W-1]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        load_len   = N_CNT;
        wr_en      = 1'b0;
        wr_sel     = MEM_SEL_X;
        ovr_set    = 1'b0;
        tx_start   = 1'b0;
        tx_first   = ACK;
        tx_count   = 8'd1;
        mac_clr_c  = 1'b0;
        mac_en_c   = 1'b0;
        mac_addr_c = 8'd0;
        case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    cnt_d = 8'd0;
                    case (bus.rx_data)
                        CMD_W:   state_d = LOAD_W;
                        CMD_B:   state_d = LOAD_B;
                        CMD_X:   state_d = LOAD_X;
                        default: begin
                            tx_start = 1'b1;
                            tx_first = NAK;
                            state_d  = RESP;
                        end
                    endcase
                end
            end
            LOAD_W, LOAD_B, LOAD_X: begin
                if (state_q == LOAD_W) begin
                    wr_sel = MEM_SEL_W;
                end else if (state_q == LOAD_B) begin
                    wr_sel   = MEM_SEL_B;
                    load_len = 8'd1;
                end
                // Extra cycle after the last byte lets its write land before CLR/ACK.
                if (cnt_q == load_len) begin
                    ovr_set = bus.rx_valid;
                    cnt_d   = 8'd0;
                    if (state_q == LOAD_X) begin
                        state_d = CLR;
                    end else begin
                        tx_start = 1'b1;
                        tx_first = ACK;
                        state_d  = RESP;
                    end
                end else if (bus.rx_valid) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                end
            end
            CLR: begin
                mac_clr_c = 1'b1;
                ovr_set   = bus.rx_valid;
                cnt_d     = 8'd0;
                state_d   = RUN;
            end
            RUN: begin
                mac_en_c   = 1'b1;
                mac_addr_c = cnt_q;
                ovr_set    = bus.rx_valid;
                if (cnt_q == N_LAST) begin
                    cnt_d = 8'd0;
                    if (MAC_LAT == 0) begin
                        tx_start = 1'b1;
                        tx_first = class_byte;
                        tx_count = RESULT_BYTES;
                        state_d  = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WAIT: begin
                ovr_set = bus.rx_valid;
                if (cnt_q == W_LAST) begin
                    cnt_d    = 8'd0;
                    tx_start = 1'b1;
                    tx_first = class_byte;
                    tx_count = RESULT_BYTES;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                ovr_set = bus.rx_valid;
                if (tx_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            mem_we_q    <= 1'b0;
            mem_sel_q   <= 2'd0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= '0;
            rx_overrun  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mem_we_q <= wr_en;
            if (wr_en) begin
                mem_sel_q   <= wr_sel;
                mem_addr_q  <= cnt_q;
                mem_wdata_q <= DATA_W'(bus.rx_data);
            end
            if (ovr_set) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    perceptron_tx_seq
`ifdef PERCEPTRON_ACC_DUMP_EN
    #(.ACC_W(ACC_W))
`endif
    u_tx_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (tx_start),
        .first_byte (tx_first),
        .n_bytes    (tx_count),
`ifdef PERCEPTRON_ACC_DUMP_EN
        .acc        (bus.acc),
`endif
        .tx_ready   (bus.tx_ready),
        .tx_data    (tx_data_w),
        .tx_valid   (tx_valid_w),
        .done       (tx_done)
    );

    assign bus.tx_data   = tx_data_w;
    assign bus.tx_valid  = tx_valid_w;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mac_clr   = mac_clr_c;
    assign bus.mac_en    = mac_en_c;
    assign bus.mac_addr  = mac_addr_c;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_perceptron_ctrl.sv
// Scoreboard bench for perceptron_ctrl with a behavioural MAC datapath; honours PERCEPTRON_ACC_DUMP_EN.
module tb_perceptron_ctrl;
    import perceptron_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 20;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_overrun;
    logic busy;

    always #5 clk = ~clk;

    perceptron_if #(.DATA_W(DW), .ACC_W(AW)) bus ();

    perceptron_ctrl #(.N_INPUTS(N), .DATA_W(DW), .ACC_W(AW), .MAC_LAT(ML)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .rx_overrun (rx_overrun),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0]  exp_tx[$];
    logic [17:0] exp_wr[$];
    int cyc = 0;
    int rx_cyc = 0;
    int tx_rise_cyc = 0;
    int clr_cnt = 0;
    int en_cnt = 0;
    logic tx_valid_d = 1'b0;

    // Behavioural datapath: register file plus accumulator.
    logic signed [7:0]    w_m[N];
    logic signed [7:0]    x_m[N];
    logic signed [7:0]    b_m = '0;
    logic signed [AW-1:0] acc_r = '0;
    assign bus.acc = acc_r;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_we) begin
            case (bus.mem_sel)
                MEM_SEL_W: w_m[int'(bus.mem_addr)] <= bus.mem_wdata;
                MEM_SEL_X: x_m[int'(bus.mem_addr)] <= bus.mem_wdata;
                default:   b_m <= bus.mem_wdata;
            endcase
        end
        if (bus.mac_clr)
            acc_r <= AW'(int'(b_m));
        else if (bus.mac_en)
            acc_r <= acc_r + AW'(int'(w_m[int'(bus.mac_addr)]) * int'(x_m[int'(bus.mac_addr)]));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a write or an accepted tx byte.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.rx_valid) rx_cyc = cyc;
            if (bus.tx_valid && !tx_valid_d) tx_rise_cyc = cyc;
            if (bus.mac_clr) clr_cnt++;
            if (bus.mac_en) begin
                chk("mac_addr", 32'(bus.mac_addr), 32'(en_cnt));
                en_cnt++;
            end
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_we: got sel=%0d addr=%0d data=%0h expected none",
                             bus.mem_sel, bus.mem_addr, bus.mem_wdata);
                end else begin
                    chk("mem_write", 32'({bus.mem_sel, bus.mem_addr, bus.mem_wdata}), 32'(exp_wr.pop_front()));
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %0h expected none", bus.tx_data);
                end else begin
                    chk("tx_byte", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
                end
            end
        end
        tx_valid_d = bus.tx_valid;
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [1:0] sel, input int addr, input logic [7:0] d);
        exp_wr.push_back({sel, 8'(addr), d});
    endtask

    task automatic expect_class(input int acc_val);
`ifdef PERCEPTRON_ACC_DUMP_EN
        logic [23:0] e;
        e = 24'(acc_val);
`endif
        exp_tx.push_back((acc_val >= 0) ? 8'h01 : 8'h00);
`ifdef PERCEPTRON_ACC_DUMP_EN
        exp_tx.push_back(e[23:16]);
        exp_tx.push_back(e[15:8]);
        exp_tx.push_back(e[7:0]);
`endif
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 || bus.tx_valid || busy) && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_complete"}, 32'(n < 400), 32'd1);
    endtask

    task automatic load_weights();
        for (int i = 0; i < N; i++) expect_wr(MEM_SEL_W, i, 8'(i + 1));
        exp_tx.push_back(ACK);
        send(CMD_W);
        for (int i = 0; i < N; i++) send(8'(i + 1));
    endtask

    task automatic run_x(input logic [7:0] xv, input int acc_val, input string name);
        clr_cnt = 0;
        en_cnt  = 0;
        for (int i = 0; i < N; i++) expect_wr(MEM_SEL_X, i, xv);
        expect_class(acc_val);
        send(CMD_X);
        for (int i = 0; i < N; i++) send(xv);
        drain(name);
        chk({name, "_latency"}, 32'(tx_rise_cyc - rx_cyc), 32'd9);
        chk({name, "_mac_clr_pulses"}, 32'(clr_cnt), 32'd1);
        chk({name, "_mac_en_cycles"}, 32'(en_cnt), 32'd4);
    endtask

    initial begin
        int  n;
        logic stall_ok;
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_sel", 32'(bus.mem_sel), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        chk("rst_mac_clr", 32'(bus.mac_clr), 32'd0);
        chk("rst_mac_en", 32'(bus.mac_en), 32'd0);
        chk("rst_mac_addr", 32'(bus.mac_addr), 32'd0);
        chk("rst_rx_overrun", 32'(rx_overrun), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        load_weights();
        drain("cmd_w");
        chk("overrun_after_w", 32'(rx_overrun), 32'd0);

        // bias -10, x=2: -10 + 2*(1+2+3+4) = 10
        expect_wr(MEM_SEL_B, 0, 8'hF6);
        exp_tx.push_back(ACK);
        send(CMD_B);
        send(8'hF6);
        drain("cmd_b_pos");
        run_x(8'd2, 10, "x_pos");

        // Hold off the ACK for bias -32 and inject a stray byte while waiting.
        bus.tx_ready = 1'b0;
        expect_wr(MEM_SEL_B, 0, 8'hE0);
        exp_tx.push_back(ACK);
        send(CMD_B);
        send(8'hE0);
        n = 0;
        while (!bus.tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall_tx_valid_up", 32'(bus.tx_valid), 32'd1);
        stall_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!(bus.tx_valid === 1'b1 && bus.tx_data === ACK)) stall_ok = 1'b0;
            if (i == 20) begin
                bus.rx_data  = 8'h33;
                bus.rx_valid = 1'b1;
            end else if (i == 21) begin
                bus.rx_valid = 1'b0;
            end
        end
        chk("stall_tx_stable", 32'(stall_ok), 32'd1);
        chk("stall_rx_overrun", 32'(rx_overrun), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        bus.tx_ready = 1'b1;
        drain("stall");

        // -32 + 20 = -12
        run_x(8'd2, -12, "x_neg");

        exp_tx.push_back(NAK);
        send(8'h41);
        drain("nak");
        load_weights();
        drain("cmd_w_after_nak");

        // Abandon an X command halfway through.
        expect_wr(MEM_SEL_X, 0, 8'd2);
        expect_wr(MEM_SEL_X, 1, 8'd2);
        send(CMD_X);
        send(8'd2);
        send(8'd2);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("midrst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("midrst_mac_clr", 32'(bus.mac_clr), 32'd0);
        chk("midrst_mac_en", 32'(bus.mac_en), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_rx_overrun", 32'(rx_overrun), 32'd0);
        chk("midrst_writes_seen", 32'(exp_wr.size()), 32'd0);
        rst = 1'b0;

        // -32 + 4*(1+2+3+4) = 8
        run_x(8'd4, 8, "x_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
